// File: rtl/tlight_pacer_pkg.sv
// Shared types for the traffic-light pacer: lamp codes, phase and pedestrian state enums,
// and the lamp-code decoder.
package tlight_pkg;

  localparam logic [2:0] LAMP_RED       = 3'b100;
  localparam logic [2:0] LAMP_RED_AMBER = 3'b110;
  localparam logic [2:0] LAMP_GREEN     = 3'b001;
  localparam logic [2:0] LAMP_AMBER     = 3'b010;

  typedef enum logic [2:0] {RED, RED_AMBER, GREEN, AMBER, INVALID} phase_t;
  typedef enum logic [1:0] {IDLE, WAITING, WALK} ped_state_t;

  function automatic phase_t decode_phase(input logic [2:0] code);
    case (code)
      LAMP_RED:       return RED;
      LAMP_RED_AMBER: return RED_AMBER;
      LAMP_GREEN:     return GREEN;
      LAMP_AMBER:     return AMBER;
      default:        return INVALID;
    endcase
  endfunction

endpackage

// File: rtl/tlight_pacer_if.sv
// Lamp feedback, pedestrian button and pacing outputs between the sequencer side
// (master) and the pacer (slave).
interface tlight_pacer_if;
  logic r;
  logic a;
  logic g;
  logic ped_req;
  logic step;
  logic ped_wait;
  logic ped_walk;
  logic sec_tick;

  modport master (output r, a, g, ped_req, input step, ped_wait, ped_walk, sec_tick);
  modport slave  (input r, a, g, ped_req, output step, ped_wait, ped_walk, sec_tick);
endinterface

// File: rtl/tlight_pacer_ped_debounce.sv
// Pedestrian button conditioner: 2-flop synchroniser followed by a stable-level filter
// that only follows the input after DEB_CYCLES consecutive cycles of disagreement.
module ped_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync_reg;
  logic          filt_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b00;
      filt_reg <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      sync_reg <= {sync_reg[0], din};
      if (sync_reg[1] == filt_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
        filt_reg <= sync_reg[1];
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign dout = filt_reg;

endmodule

// File: rtl/tlight_pacer.sv
// Phase dwell timer and pedestrian request handler feeding the traffic-light sequencer.
// Define TLIGHT_PACER_DEBOUNCE_EN to condition ped_req through ped_debounce.
module tlight_pacer
  import tlight_pkg::*;
#(
  parameter int PRESCALE    = 50_000_000,
  parameter int T_RED       = 5,
  parameter int T_RED_AMBER = 1,
  parameter int T_GREEN     = 5,
  parameter int T_AMBER     = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  tlight_pacer_if.slave bus
);

  localparam int             PW         = $clog2(PRESCALE);
  localparam logic [PW-1:0]  PRESC_MAX  = PW'(PRESCALE - 1);

  if (PRESCALE < 2 || DEB_CYCLES < 1 ||
      T_RED < 1 || T_RED > 255 || T_RED_AMBER < 1 || T_RED_AMBER > 255 ||
      T_GREEN < 1 || T_GREEN > 255 || T_AMBER < 1 || T_AMBER > 255) begin : g_param_check
    $error("tlight_pacer: illegal parameter value");
  end

  logic [2:0]    code;
  phase_t        phase;
  logic          entry;
  logic          tick;
  logic          step_c;
  logic [7:0]    t_load;

  logic [PW-1:0] presc_reg, presc_eff, presc_next;
  logic [7:0]    dwell_reg, dwell_eff, dwell_next;
  logic [2:0]    prev_code_reg;
  logic          armed_reg, armed_eff, armed_next;

  ped_state_t    ped_reg, ped_next;
  logic          ped_lvl;
  logic          ped_prev_reg;
  logic          ped_rise;

  assign code  = {bus.r, bus.a, bus.g};
  assign phase = decode_phase(code);
  assign entry = (code != prev_code_reg);

  always_comb begin
    t_load = 8'd0;
    case (phase)
      RED:       t_load = 8'(T_RED - 1);
      RED_AMBER: t_load = 8'(T_RED_AMBER - 1);
      GREEN:     t_load = 8'(T_GREEN - 1);
      AMBER:     t_load = 8'(T_AMBER - 1);
      default:   t_load = 8'd0;
    endcase
  end

  // A phase entry restarts the second, the dwell and the single-shot arm in the same cycle.
  assign presc_eff = entry ? '0 : presc_reg;
  assign tick      = ~entry & (presc_eff == PRESC_MAX);
  assign armed_eff = entry | armed_reg;
  assign dwell_eff = entry ? t_load : dwell_reg;

  always_comb begin
    step_c     = 1'b0;
    armed_next = armed_eff;
    dwell_next = dwell_eff;
    presc_next = (presc_eff == PRESC_MAX) ? '0 : presc_eff + 1'b1;
    if (phase == INVALID) begin
      step_c = armed_eff & rst_n;
    end else begin
      step_c = tick & armed_eff & (dwell_eff == 8'd0);
    end
    if (step_c) begin
      armed_next = 1'b0;
    end else if (tick && phase != INVALID) begin
      if (phase == GREEN && ped_reg == WAITING && dwell_eff > 8'd1) begin
        dwell_next = 8'd0;
      end else begin
        dwell_next = dwell_eff - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg     <= '0;
      dwell_reg     <= 8'd0;
      prev_code_reg <= 3'b000;
      armed_reg     <= 1'b1;
    end else begin
      presc_reg     <= presc_next;
      dwell_reg     <= dwell_next;
      prev_code_reg <= code;
      armed_reg     <= armed_next;
    end
  end

`ifdef TLIGHT_PACER_DEBOUNCE_EN
  ped_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ped_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.ped_req),
    .dout  (ped_lvl)
  );
`else
  assign ped_lvl = bus.ped_req;
`endif

  assign ped_rise = ped_lvl & ~ped_prev_reg;

  always_comb begin
    ped_next = ped_reg;
    case (ped_reg)
      IDLE:    if (ped_rise) ped_next = (entry && phase == RED) ? WALK : WAITING;
      WAITING: if (entry && phase == RED) ped_next = WALK;
      WALK:    if (entry && phase != RED) ped_next = IDLE;
      default: ped_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_reg      <= IDLE;
      ped_prev_reg <= 1'b0;
    end else begin
      ped_reg      <= ped_next;
      ped_prev_reg <= ped_lvl;
    end
  end

  assign bus.step     = step_c;
  assign bus.sec_tick = tick;
  assign bus.ped_wait = (ped_reg == WAITING);
  assign bus.ped_walk = (ped_reg == WALK);

endmodule

// File: tb/tb_tlight_pacer.sv
// Bench for tlight_pacer: a lamp sequencer advancing on step, and a tick/dwell reference
// model expressed in seconds-since-entry terms, checked every cycle.
module tb_tlight_pacer;

  localparam int P   = 4;
  localparam int TR  = 3;
  localparam int TRA = 1;
  localparam int TG  = 5;
  localparam int TA  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tlight_pacer_if bus ();

  tlight_pacer #(
    .PRESCALE(P), .T_RED(TR), .T_RED_AMBER(TRA), .T_GREEN(TG), .T_AMBER(TA), .DEB_CYCLES(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int         m_n, m_target, m_ped, cyc_no, entry_cyc;
  bit         m_stepped, m_ped_prev, hold, last_entry, last_ds;
  logic [2:0] m_prev, last_code;
  int         off_by_code [8];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc_no);
  endtask

  function automatic int t_of(input logic [2:0] c);
    case (c)
      3'b100:  return TR;
      3'b110:  return TRA;
      3'b001:  return TG;
      3'b010:  return TA;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] next_code(input logic [2:0] c);
    case (c)
      3'b100:  return 3'b110;
      3'b110:  return 3'b001;
      3'b001:  return 3'b010;
      3'b010:  return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  task automatic set_lamp(input logic [2:0] c);
    {bus.r, bus.a, bus.g} = c;
  endtask

  task automatic model_reset();
    m_n = 0; m_stepped = 0; m_target = 0; m_ped = 0; m_ped_prev = 0;
    m_prev = 3'b000; entry_cyc = cyc_no;
  endtask

  // One clock cycle: check at the falling edge, advance model and sequencer after the rising edge.
  task automatic cyc();
    logic [2:0] code;
    bit entry, tick, es, ds, rise;
    int k, t;
    @(negedge clk);
    code  = {bus.r, bus.a, bus.g};
    t     = t_of(code);
    entry = (code != m_prev);
    if (entry) begin
      m_n = 0; m_stepped = 0; m_target = t; entry_cyc = cyc_no;
    end
    tick = ((m_n % P) == P - 1);
    k    = (m_n + 1) / P;
    if (t != 0) es = tick && !m_stepped && (k == m_target);
    else        es = !m_stepped;
    if (t != 0 && tick && !es && !m_stepped && code == 3'b001 && m_ped == 1 && (m_target - k) > 1)
      m_target = k + 1;
    ds = bus.step;
    chk("step", int'(ds), int'(es));
    chk("sec_tick", int'(bus.sec_tick), int'(tick));
    chk("ped_wait", int'(bus.ped_wait), int'(m_ped == 1));
    chk("ped_walk", int'(bus.ped_walk), int'(m_ped == 2));
    if (ds) begin
      off_by_code[code] = cyc_no - entry_cyc;
      $display("cycle %0d: step in code %b, offset %0d", cyc_no, code, cyc_no - entry_cyc);
    end
    rise = bus.ped_req && !m_ped_prev;
    case (m_ped)
      0: if (rise) m_ped = (entry && code == 3'b100) ? 2 : 1;
      1: if (entry && code == 3'b100) m_ped = 2;
      default: if (entry && code != 3'b100) m_ped = 0;
    endcase
    m_ped_prev = bus.ped_req;
    m_prev     = code;
    if (es) m_stepped = 1;
    m_n++;
    last_entry = entry; last_code = code; last_ds = ds;
    @(posedge clk); #1;
    cyc_no++;
    if (ds && !hold) set_lamp(next_code(code));
  endtask

  task automatic wait_entry(input logic [2:0] want, input string tag);
    int b = 0;
    do begin
      cyc(); b++;
    end while (!(last_entry && last_code == want) && b < 200);
    chk(tag, int'(b < 200), 1);
  endtask

  initial begin
    int cnt;
    cyc_no = 0; hold = 0;
    for (int i = 0; i < 8; i++) off_by_code[i] = -1;
    rst_n = 1'b0; set_lamp(3'b000); bus.ped_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_step", int'(bus.step), 0);
    chk("rst_sec_tick", int'(bus.sec_tick), 0);
    chk("rst_ped_wait", int'(bus.ped_wait), 0);
    chk("rst_ped_walk", int'(bus.ped_walk), 0);
    rst_n = 1'b1;

    // Startup from 000 and a full unrequested cycle
    repeat (100) cyc();
    chk("off_green", off_by_code[1], 19);
    chk("off_amber", off_by_code[2], 7);
    chk("off_red", off_by_code[4], 11);
    chk("off_red_amber", off_by_code[6], 3);

    // Request pulse at GREEN E+2 shortens green to 8 cycles
    wait_entry(3'b001, "wait_green1");
    cyc();
    bus.ped_req = 1'b1;
    cyc();
    bus.ped_req = 1'b0;
    chk("wait_after_req", int'(bus.ped_wait), 1);
    repeat (12) cyc();
    chk("short_off_green", off_by_code[1], 7);

    // A second request during WALK is ignored
    wait_entry(3'b100, "wait_red");
    chk("walk_on_red", int'(bus.ped_walk), 1);
    cyc();
    bus.ped_req = 1'b1;
    repeat (2) cyc();
    bus.ped_req = 1'b0;
    chk("walk_ignores_req", int'(bus.ped_wait), 0);
    wait_entry(3'b110, "wait_red_amber");
    chk("walk_clears", int'(bus.ped_walk), 0);

    // Sequencer stalls in AMBER: exactly one step, then resumes after a forced change
    wait_entry(3'b010, "wait_amber");
    hold = 1; cnt = 0;
    repeat (30) begin cyc(); cnt += int'(last_ds); end
    chk("hold_single_step", cnt, 1);
    set_lamp(3'b100); hold = 0; cnt = 0;
    repeat (40) begin cyc(); cnt += int'(last_ds); end
    chk("resume_after_hold", int'(cnt > 0), 1);

    // Asynchronous reset at GREEN E+6 with a request pending
    wait_entry(3'b001, "wait_green2");
    cyc();
    bus.ped_req = 1'b1;
    cyc();
    bus.ped_req = 1'b0;
    repeat (3) cyc();
    chk("pre_rst_wait", int'(bus.ped_wait), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_step", int'(bus.step), 0);
    chk("async_sec_tick", int'(bus.sec_tick), 0);
    chk("async_ped_wait", int'(bus.ped_wait), 0);
    chk("async_ped_walk", int'(bus.ped_walk), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (25) cyc();
    chk("post_rst_green", off_by_code[1], 19);

    // Randomised requests and occasional invalid lamp codes
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 11) == 0) bus.ped_req = ~bus.ped_req;
      if ($urandom_range(0, 149) == 0) begin
        case ($urandom_range(0, 3))
          0:       set_lamp(3'b000);
          1:       set_lamp(3'b011);
          2:       set_lamp(3'b101);
          default: set_lamp(3'b111);
        endcase
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc_no);
    $fatal(1, "timeout");
  end

endmodule
